jzjpcc_memory_stage: RTL and testbench
======================================

JZJPCC_MEMORY_STAGE -- requirements
Module: jzjpcc_memory_stage

Interface
REQ-001 clock  in  1  sole clock; all state updates on rising edge.
REQ-002 reset_n  in  1  reset, synchronous, active-low.
REQ-003 valid_execute  in  1  execute-stage instruction valid.
REQ-004 isLoad_execute, isStore_execute  in  1 each  memory op type; both high is illegal.
REQ-005 funct3_execute  in  3  RV32I load/store funct3.
REQ-006 memAddress_execute  in  30  word address, byte address bits [31:2].
REQ-007 memByteOffset_execute  in  2  byte address bits [1:0].
REQ-008 memByteMask_execute  in  4  byte mask; bit 3 = byte at offset 0.
REQ-009 memDataToWrite_execute  in  32  store word already placed in memory byte order.
REQ-010 aluResult_execute  in  32  result for non-memory instructions.
REQ-011 rdIndex_execute  in  5; rdWriteEnable_execute  in  1.
REQ-012 memRequest  out  1; memWriteEnable  out  1; memAddress  out  30; memByteMask  out  4; memWriteData  out  32.
REQ-013 memReadData  in  32; memAck  in  1  completes the current request; read data valid with ack.
REQ-014 stall_memory  out  1  freezes all upstream stages while high.
REQ-015 valid_writeback  out  1; rdIndex_writeback  out  5; rdWriteEnable_writeback  out  1; rdWriteData_writeback  out  32.

Function
REQ-016 M register SHALL capture all *_execute inputs on each edge where stall_memory=0; it SHALL hold while stall_memory=1.
REQ-017 memRequest SHALL equal M.valid & (M.isLoad | M.isStore) & state!=DONE; memWriteEnable = memRequest & M.isStore; address, mask and write data driven from M.
REQ-018 FSM states IDLE, WAIT, DONE; IDLE->WAIT when memRequest & ~memAck; WAIT->IDLE on memAck; IDLE stays IDLE on same-cycle ack.
REQ-019 DONE is unused in normal flow; reaching it (ack with no request) SHALL be impossible; memAck while memRequest=0 SHALL be ignored.
REQ-020 stall_memory SHALL equal memRequest & ~memAck; zero-wait-state memory gives 1-cycle throughput.
REQ-021 Request outputs SHALL remain stable from assertion until the acking cycle.
REQ-022 Writeback register SHALL capture on each edge where stall_memory=0; valid_writeback = M.valid; no bubble is inserted.
REQ-023 rdWriteData_writeback SHALL be the aligned load result for loads, otherwise M.aluResult.
REQ-024 rdWriteEnable_writeback SHALL be M.rdWriteEnable & M.valid; stores force it to 0.
REQ-025 Memory word order: bits[31:24]=offset 0, [23:16]=1, [15:8]=2, [7:0]=3.
REQ-026 Byte load: bits [31-8*offset -: 8]; funct3[2]=0 sign-extends, =1 zero-extends.
REQ-027 Halfword load: offset[1]=0 -> {w[23:16],w[31:24]}; offset[1]=1 -> {w[7:0],w[15:8]}; extension per funct3[2].
REQ-028 Word load: {w[7:0],w[15:8],w[23:16],w[31:24]}.
REQ-029 Load funct3[1:0]=11 or misaligned access SHALL produce X-free data (zero); misalignment is not trapped.
REQ-030 Load latency: one cycle after the acking edge, the result is on rdWriteData_writeback.

Reset
REQ-031 While reset_n=0 at an edge: state=IDLE, M.valid=0, all writeback outputs 0; memRequest and stall_memory are 0 the cycle after.
REQ-032 Reset during WAIT SHALL abandon the request unconditionally; a late memAck is ignored per REQ-019.

Structure
REQ-033 Package jzjpcc_mem_types SHALL hold the FSM state enum, funct3 width constants and the M-register struct.
REQ-034 Sub-module jzjpcc_load_aligner (combinational) SHALL implement REQ-025..029.

Verification
REQ-035 LB, offset 2, w=32'h1122_83_44, ack same cycle -> rdWriteData=32'hFFFF_FF83, no stall.
REQ-036 LHU, offset 0, w=32'hCDAB_0000 -> 32'h0000_ABCD; LH same word -> 32'hFFFF_ABCD.
REQ-037 LW, w=32'h7856_3412, ack after 3 cycles -> stall high exactly 3 cycles, request outputs constant, result 32'h1234_5678.
REQ-038 SW mask 4'b1111 data 32'hEFBE_ADDE -> memWriteEnable=1 with unchanged data and mask; rdWriteEnable_writeback=0.
REQ-039 Non-memory instr, aluResult=32'h0000_0042, rd=5 -> writeback next cycle with rd=5, data 32'h42, no memRequest.
REQ-040 reset_n low during WAIT, then memAck pulses -> outputs zero, ack ignored, next load completes normally.

Source files
------------

// File: rtl/jzjpcc_memory_stage_pkg.sv
// Shared types for the JZJ pipelined core memory stage: FSM states, funct3
// encodings and the M pipeline register layout.
package jzjpcc_mem_types;

    localparam int FUNCT3_W = 3;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic                valid;
        logic                is_load;
        logic                is_store;
        logic [FUNCT3_W-1:0] funct3;
        logic [29:0]         addr;
        logic [1:0]          byte_offset;
        logic [3:0]          byte_mask;
        logic [31:0]         write_data;
        logic [31:0]         alu_result;
        logic [4:0]          rd_index;
        logic                rd_write_enable;
    } m_reg_t;

endpackage

// File: rtl/jzjpcc_memory_stage_if.sv
// Data-memory bus between the memory stage (master) and the memory (slave).
// A request is held until the cycle in which memAck is high.
interface jzjpcc_memory_stage_if;
    logic        memRequest;
    logic        memWriteEnable;
    logic [29:0] memAddress;
    logic [3:0]  memByteMask;
    logic [31:0] memWriteData;
    logic [31:0] memReadData;
    logic        memAck;

    modport master (
        output memRequest,
        output memWriteEnable,
        output memAddress,
        output memByteMask,
        output memWriteData,
        input  memReadData,
        input  memAck
    );

    modport slave (
        input  memRequest,
        input  memWriteEnable,
        input  memAddress,
        input  memByteMask,
        input  memWriteData,
        output memReadData,
        output memAck
    );
endinterface

// File: rtl/jzjpcc_memory_stage_load_aligner.sv
// Turns a memory-order read word into an RV32I load result: byte/half/word
// selection by offset, sign or zero extension; unsupported cases give zero.
module jzjpcc_load_aligner
    import jzjpcc_mem_types::*;
(
    input  logic [FUNCT3_W-1:0] funct3,
    input  logic [1:0]          byte_offset,
    input  logic [31:0]         mem_word,
    output logic [31:0]         load_data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sign_ext;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        load_data = '0;
        sign_ext  = ~funct3[2];

        case (byte_offset)
            2'd0:    byte_sel = mem_word[31:24];
            2'd1:    byte_sel = mem_word[23:16];
            2'd2:    byte_sel = mem_word[15:8];
            default: byte_sel = mem_word[7:0];
        endcase

        // Memory order is big-endian within the word; RISC-V values are little-endian.
        half_sel = byte_offset[1] ? {mem_word[7:0], mem_word[15:8]}
                                  : {mem_word[23:16], mem_word[31:24]};

        case (funct3[1:0])
            SIZE_BYTE: load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SIZE_HALF: begin
                if (!byte_offset[0]) begin
                    load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
                end
            end
            SIZE_WORD: begin
                if (byte_offset == 2'd0) begin
                    load_data = {mem_word[7:0], mem_word[15:8], mem_word[23:16], mem_word[31:24]};
                end
            end
            default: load_data = '0;
        endcase
    end
endmodule

// File: rtl/jzjpcc_memory_stage.sv
// Memory stage of the JZJ pipelined core: holds one instruction in the M register,
// drives its bus access, stalls upstream until acknowledged, and feeds writeback.
module jzjpcc_memory_stage
    import jzjpcc_mem_types::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 valid_execute,
    input  logic                 isLoad_execute,
    input  logic                 isStore_execute,
    input  logic [FUNCT3_W-1:0]  funct3_execute,
    input  logic [29:0]          memAddress_execute,
    input  logic [1:0]           memByteOffset_execute,
    input  logic [3:0]           memByteMask_execute,
    input  logic [31:0]          memDataToWrite_execute,
    input  logic [31:0]          aluResult_execute,
    input  logic [4:0]           rdIndex_execute,
    input  logic                 rdWriteEnable_execute,
    jzjpcc_memory_stage_if.master mem,
    output logic                 stall_memory,
    output logic                 valid_writeback,
    output logic [4:0]           rdIndex_writeback,
    output logic                 rdWriteEnable_writeback,
    output logic [31:0]          rdWriteData_writeback
);
    m_reg_t      m_q;
    m_reg_t      m_d;
    mem_state_t  state_q;
    mem_state_t  state_d;
    logic        mem_request;
    logic [31:0] load_data;

    always_comb begin
        m_d.valid           = valid_execute;
        m_d.is_load         = isLoad_execute;
        m_d.is_store        = isStore_execute;
        m_d.funct3          = funct3_execute;
        m_d.addr            = memAddress_execute;
        m_d.byte_offset     = memByteOffset_execute;
        m_d.byte_mask       = memByteMask_execute;
        m_d.write_data      = memDataToWrite_execute;
        m_d.alu_result      = aluResult_execute;
        m_d.rd_index        = rdIndex_execute;
        m_d.rd_write_enable = rdWriteEnable_execute;
    end

    // NOTE: only valid is reset; the payload is ignored while valid is low, so it needs no reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            m_q.valid <= 1'b0;
        end else if (!stall_memory) begin
            m_q <= m_d;
        end
    end

    assign mem_request        = m_q.valid & (m_q.is_load | m_q.is_store) & (state_q != ST_DONE);
    assign stall_memory       = mem_request & ~mem.memAck;
    assign mem.memRequest     = mem_request;
    assign mem.memWriteEnable = mem_request & m_q.is_store;
    assign mem.memAddress     = m_q.addr;
    assign mem.memByteMask    = m_q.byte_mask;
    assign mem.memWriteData   = m_q.write_data;

    // An ack with no request never moves the FSM, so DONE stays unreachable.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mem_request && !mem.memAck) state_d = ST_WAIT;
            ST_WAIT: if (mem_request && mem.memAck)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    jzjpcc_load_aligner u_load_aligner (
        .funct3      (m_q.funct3),
        .byte_offset (m_q.byte_offset),
        .mem_word    (mem.memReadData),
        .load_data   (load_data)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid_writeback         <= 1'b0;
            rdIndex_writeback       <= '0;
            rdWriteEnable_writeback <= 1'b0;
            rdWriteData_writeback   <= '0;
        end else if (!stall_memory) begin
            valid_writeback         <= m_q.valid;
            rdIndex_writeback       <= m_q.rd_index;
            rdWriteEnable_writeback <= m_q.valid & m_q.rd_write_enable & ~m_q.is_store;
            rdWriteData_writeback   <= (m_q.valid & m_q.is_load) ? load_data : m_q.alu_result;
        end
    end
endmodule

// File: tb/tb_jzjpcc_memory_stage.sv
// Randomised scoreboard bench for jzjpcc_memory_stage with a byte-addressed
// reference memory model and a variable-latency bus responder.
module tb_jzjpcc_memory_stage;
    import jzjpcc_mem_types::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        valid_execute, isLoad_execute, isStore_execute;
    logic [2:0]  funct3_execute;
    logic [29:0] memAddress_execute;
    logic [1:0]  memByteOffset_execute;
    logic [3:0]  memByteMask_execute;
    logic [31:0] memDataToWrite_execute, aluResult_execute;
    logic [4:0]  rdIndex_execute;
    logic        rdWriteEnable_execute;
    logic        stall_memory, valid_writeback;
    logic [4:0]  rdIndex_writeback;
    logic        rdWriteEnable_writeback;
    logic [31:0] rdWriteData_writeback;

    always #5 clock = ~clock;

    jzjpcc_memory_stage_if mem_bus();

    jzjpcc_memory_stage dut (
        .clock                   (clock),
        .reset_n                 (reset_n),
        .valid_execute           (valid_execute),
        .isLoad_execute          (isLoad_execute),
        .isStore_execute         (isStore_execute),
        .funct3_execute          (funct3_execute),
        .memAddress_execute      (memAddress_execute),
        .memByteOffset_execute   (memByteOffset_execute),
        .memByteMask_execute     (memByteMask_execute),
        .memDataToWrite_execute  (memDataToWrite_execute),
        .aluResult_execute       (aluResult_execute),
        .rdIndex_execute         (rdIndex_execute),
        .rdWriteEnable_execute   (rdWriteEnable_execute),
        .mem                     (mem_bus),
        .stall_memory            (stall_memory),
        .valid_writeback         (valid_writeback),
        .rdIndex_writeback       (rdIndex_writeback),
        .rdWriteEnable_writeback (rdWriteEnable_writeback),
        .rdWriteData_writeback   (rdWriteData_writeback)
    );

    typedef struct packed {
        logic        valid, ld, st;
        logic [2:0]  f3;
        logic [29:0] addr;
        logic [1:0]  off;
        logic [3:0]  mask;
        logic [31:0] wdata, alu;
        logic [4:0]  rd;
        logic        rdwe;
    } instr_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
    } exp_t;

    typedef struct packed {
        logic        we;
        logic [29:0] addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
    } bus_t;

    int checks = 0;
    int failures = 0;
    exp_t exp_q[$];
    bus_t bus_q[$];
    logic [7:0] ref_mem [64];
    logic [7:0] bus_mem [64];
    int forced_lat = -1;
    int cur_lat = -1;
    bit spurious_ack = 1'b0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, actual, expected, $time);
        end
    endtask

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    // Reference load: little-endian bytes at a byte address, plain arithmetic.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int ba);
        logic [31:0] v;
        v = 32'd0;
        case (f3[1:0])
            2'b00: begin
                v = 32'(ref_mem[ba]);
                if (!f3[2] && v >= 32'd128) v = v - 32'd256;
            end
            2'b01: if (ba % 2 == 0) begin
                v = 32'(ref_mem[ba]) + 32'(ref_mem[ba+1]) * 32'd256;
                if (!f3[2] && v >= 32'd32768) v = v - 32'd65536;
            end
            2'b10: if (ba % 4 == 0) begin
                for (int k = 0; k < 4; k++) v = v + (32'(ref_mem[ba+k]) << (8 * k));
            end
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    task automatic set_word(input int idx, input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            ref_mem[idx*4+k] = 8'(w >> (24 - 8 * k));
            bus_mem[idx*4+k] = 8'(w >> (24 - 8 * k));
        end
    endtask

    task automatic model_accept(input instr_t in);
        exp_t e;
        bus_t b;
        int ba;
        if (!in.valid) return;
        ba = int'({in.addr[3:0], in.off});
        e.rd = in.rd;
        e.we = in.rdwe & ~in.st;
        e.data = in.ld ? ref_load(in.f3, ba) : in.alu;
        exp_q.push_back(e);
        if (in.ld || in.st) begin
            b.we = in.st;
            b.addr = in.addr;
            b.mask = in.mask;
            b.wdata = in.wdata;
            bus_q.push_back(b);
        end
        if (in.st) begin
            for (int k = 0; k < 4; k++)
                if (in.mask[3-k]) ref_mem[int'(in.addr[3:0])*4+k] = 8'(in.wdata >> (24 - 8 * k));
        end
    endtask

    task automatic drive(input instr_t in);
        valid_execute          = in.valid;
        isLoad_execute         = in.ld;
        isStore_execute        = in.st;
        funct3_execute         = in.f3;
        memAddress_execute     = in.addr;
        memByteOffset_execute  = in.off;
        memByteMask_execute    = in.mask;
        memDataToWrite_execute = in.wdata;
        aluResult_execute      = in.alu;
        rdIndex_execute        = in.rd;
        rdWriteEnable_execute  = in.rdwe;
    endtask

    task automatic issue(input instr_t in);
        int guard;
        guard = 0;
        drive(in);
        @(negedge clock);
        while (stall_memory) begin
            guard++;
            if (guard > 50) begin
                check("issue_stall_bound", 32'(stall_memory), 32'd0);
                finish_run();
            end
            @(negedge clock);
        end
        @(posedge clock);
        model_accept(in);
        #2;
    endtask

    function automatic instr_t mk(input logic ld, input logic st, input logic [2:0] f3, input int idx,
                                  input logic [1:0] off, input logic [3:0] mask, input logic [31:0] wdata,
                                  input logic [31:0] alu, input logic [4:0] rd, input logic rdwe);
        instr_t in;
        in.valid = 1'b1; in.ld = ld; in.st = st; in.f3 = f3;
        in.addr = 30'(idx); in.off = off; in.mask = mask; in.wdata = wdata;
        in.alu = alu; in.rd = rd; in.rdwe = rdwe;
        return in;
    endfunction

    function automatic instr_t rand_instr();
        instr_t in;
        int kind;
        logic [2:0] ld_f3 [8];
        ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b000, 3'b010, 3'b011};
        kind = $urandom_range(0, 9);
        in.valid = (kind != 0);
        in.ld = (kind >= 1 && kind <= 4) || (kind == 0 && $urandom_range(0, 1) == 1);
        in.st = (kind >= 5 && kind <= 7);
        in.f3 = in.ld ? ld_f3[$urandom_range(0, 7)] : 3'($urandom_range(0, 2));
        if ($urandom_range(0, 15) == 0) in.f3 = 3'($urandom);
        in.addr = {26'($urandom), 4'($urandom)};
        in.off = 2'($urandom);
        if ($urandom_range(0, 1) == 1) in.off = (in.f3[1:0] == 2'b10) ? 2'b00 : (in.off & 2'b10);
        in.mask = 4'($urandom);
        in.wdata = $urandom;
        in.alu = $urandom;
        in.rd = 5'($urandom);
        in.rdwe = 1'($urandom);
        return in;
    endfunction

    // Bus responder: writes on the acking edge, random or forced wait states.
    logic        s_req, s_ack, s_we, s_rst;
    logic [29:0] s_addr;
    logic [3:0]  s_mask;
    logic [31:0] s_wdata;
    always @(negedge clock) begin
        s_req = mem_bus.memRequest; s_ack = mem_bus.memAck; s_we = mem_bus.memWriteEnable;
        s_addr = mem_bus.memAddress; s_mask = mem_bus.memByteMask; s_wdata = mem_bus.memWriteData;
        s_rst = reset_n;
    end

    initial begin
        int remaining;
        int idx;
        remaining = -1;
        mem_bus.memAck = 1'b0;
        mem_bus.memReadData = 32'd0;
        forever begin
            @(posedge clock);
            if (s_rst && s_req && s_ack) begin
                if (s_we)
                    for (int k = 0; k < 4; k++)
                        if (s_mask[3-k]) bus_mem[int'(s_addr[3:0])*4+k] = 8'(s_wdata >> (24 - 8 * k));
                remaining = -1;
            end
            if (!s_rst) remaining = -1;
            #1;
            mem_bus.memAck = 1'b0;
            mem_bus.memReadData = $urandom;
            if (mem_bus.memRequest) begin
                if (remaining < 0) begin
                    remaining = (forced_lat >= 0) ? forced_lat : $urandom_range(0, 3);
                    cur_lat = remaining;
                end
                if (remaining == 0) begin
                    idx = int'(mem_bus.memAddress[3:0]) * 4;
                    mem_bus.memAck = 1'b1;
                    mem_bus.memReadData = {bus_mem[idx], bus_mem[idx+1], bus_mem[idx+2], bus_mem[idx+3]};
                end else begin
                    remaining--;
                end
            end
            if (spurious_ack) mem_bus.memAck = 1'b1;
        end
    end

    // Monitor: compares writeback against the scoreboard, bus fields, hold and stall length.
    logic        p_stall, p_rst;
    logic        p_we;
    logic [29:0] p_addr;
    logic [3:0]  p_mask;
    logic [31:0] p_wdata;
    bit          primed = 1'b0;
    int          stall_run = 0;
    always @(negedge clock) begin
        exp_t e;
        bus_t b;
        if (primed) begin
            if (!p_rst) begin
                check("rst_valid_wb", 32'(valid_writeback), 32'd0);
                check("rst_rd_wb", 32'(rdIndex_writeback), 32'd0);
                check("rst_we_wb", 32'(rdWriteEnable_writeback), 32'd0);
                check("rst_data_wb", rdWriteData_writeback, 32'd0);
                check("rst_req", 32'(mem_bus.memRequest), 32'd0);
                check("rst_stall", 32'(stall_memory), 32'd0);
            end else if (p_stall) begin
                check("hold_req", 32'(mem_bus.memRequest), 32'd1);
                check("hold_we", 32'(mem_bus.memWriteEnable), 32'(p_we));
                check("hold_addr", 32'(mem_bus.memAddress), 32'(p_addr));
                check("hold_mask", 32'(mem_bus.memByteMask), 32'(p_mask));
                check("hold_wdata", mem_bus.memWriteData, p_wdata);
            end else if (valid_writeback) begin
                check("wb_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("wb_rd", 32'(rdIndex_writeback), 32'(e.rd));
                    check("wb_we", 32'(rdWriteEnable_writeback), 32'(e.we));
                    check("wb_data", rdWriteData_writeback, e.data);
                end
            end
        end
        check("stall_eq", 32'(stall_memory), 32'(mem_bus.memRequest & ~mem_bus.memAck));
        if (reset_n) begin
            if (stall_memory) stall_run++;
            if (mem_bus.memRequest && mem_bus.memAck) begin
                check("stall_cycles", 32'(stall_run), 32'(cur_lat));
                stall_run = 0;
                check("bus_pending", 32'(bus_q.size() > 0), 32'd1);
                if (bus_q.size() > 0) begin
                    b = bus_q.pop_front();
                    check("bus_we", 32'(mem_bus.memWriteEnable), 32'(b.we));
                    check("bus_addr", 32'(mem_bus.memAddress), 32'(b.addr));
                    check("bus_mask", 32'(mem_bus.memByteMask), 32'(b.mask));
                    check("bus_wdata", mem_bus.memWriteData, b.wdata);
                end
            end
        end else begin
            stall_run = 0;
        end
        p_stall = stall_memory; p_rst = reset_n; p_we = mem_bus.memWriteEnable;
        p_addr = mem_bus.memAddress; p_mask = mem_bus.memByteMask; p_wdata = mem_bus.memWriteData;
        primed = 1'b1;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL global_timeout reached at %0t", $time);
        finish_run();
    end

    initial begin
        instr_t nop;
        nop = '0;
        drive(nop);
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = 8'($urandom);
            bus_mem[i] = ref_mem[i];
        end
        repeat (3) @(posedge clock);
        #2 reset_n = 1'b1;
        issue(nop);

        forced_lat = 0;
        set_word(1, 32'h1122_8344);
        issue(mk(1'b1, 1'b0, 3'b000, 1, 2'd2, 4'b0010, 32'h0, 32'h0, 5'd3, 1'b1));
        set_word(2, 32'hCDAB_0000);
        issue(mk(1'b1, 1'b0, 3'b101, 2, 2'd0, 4'b1100, 32'h0, 32'h0, 5'd4, 1'b1));
        issue(mk(1'b1, 1'b0, 3'b001, 2, 2'd0, 4'b1100, 32'h0, 32'h0, 5'd6, 1'b1));
        issue(nop);
        forced_lat = 3;
        set_word(3, 32'h7856_3412);
        issue(mk(1'b1, 1'b0, 3'b010, 3, 2'd0, 4'b1111, 32'h0, 32'h0, 5'd8, 1'b1));
        forced_lat = 1;
        issue(mk(1'b0, 1'b1, 3'b010, 4, 2'd0, 4'b1111, 32'hEFBE_ADDE, 32'h0, 5'd7, 1'b1));
        forced_lat = 0;
        issue(mk(1'b1, 1'b0, 3'b010, 4, 2'd0, 4'b1111, 32'h0, 32'h0, 5'd9, 1'b1));
        issue(mk(1'b0, 1'b0, 3'b000, 0, 2'd0, 4'b0000, 32'h0, 32'h0000_0042, 5'd5, 1'b1));
        issue(nop);

        // Reset while a load is waiting, then stray acks, then a normal load.
        forced_lat = 8;
        issue(mk(1'b1, 1'b0, 3'b010, 5, 2'd0, 4'b1111, 32'h0, 32'h0, 5'd10, 1'b1));
        drive(nop);
        repeat (2) @(negedge clock);
        check("wait_stall", 32'(stall_memory), 32'd1);
        @(posedge clock);
        #2 reset_n = 1'b0;
        exp_q.delete();
        bus_q.delete();
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
        spurious_ack = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("spur_req", 32'(mem_bus.memRequest), 32'd0);
            check("spur_stall", 32'(stall_memory), 32'd0);
            check("spur_wb", 32'(valid_writeback), 32'd0);
        end
        spurious_ack = 1'b0;
        @(posedge clock);
        #2 forced_lat = 1;
        issue(mk(1'b1, 1'b0, 3'b010, 5, 2'd0, 4'b1111, 32'h0, 32'h0, 5'd11, 1'b1));
        issue(nop);
        forced_lat = -1;

        for (int i = 0; i < 300; i++) issue(rand_instr());
        repeat (3) issue(nop);
        repeat (3) @(negedge clock);
        check("drain_wb", 32'(exp_q.size()), 32'd0);
        check("drain_bus", 32'(bus_q.size()), 32'd0);
        finish_run();
    end
endmodule
